// File: rtl/ct_clock_cross_lvl_if.sv
// ct_clock_cross_lvl_if: valid/ready word stream bundle.
// master drives data/valid and samples ready; slave is the other end.
interface ct_clock_cross_lvl_if #(
    parameter int WIDTH = 256
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;

    modport master (
        output data,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        output ready
    );
endinterface

// File: rtl/ct_clock_cross_lvl.sv
// ct_clock_cross_lvl: dual-clock valid/ready FIFO with fill levels and almost-full.
// Define CT_CLOCK_CROSS_REGOUT_EN for a 2-entry registered output skid stage.
module ct_clock_cross_lvl #(
    parameter int WIDTH       = 256,
    parameter int ADDR_W      = 5,
    parameter int SYNC_STAGES = 3,
    parameter int WR_DELAY    = 2,
    parameter int AFULL_LVL   = (2**ADDR_W) - 4
) (
    input  logic                 rdclk,
    input  logic                 wrclk,
    input  logic                 arst,
    ct_clock_cross_lvl_if.slave  wr,
    output logic [ADDR_W:0]      o_wr_used,
    output logic                 o_almost_full,
    ct_clock_cross_lvl_if.master rd,
    output logic [ADDR_W:0]      o_rd_used
);
    localparam int PW    = ADDR_W + 1;
    localparam int DEPTH = 2**ADDR_W;

    typedef logic [PW-1:0] ptr_t;

    localparam ptr_t TOP2    = ptr_t'(3) << (PW - 2);
    localparam ptr_t AFULL_P = ptr_t'(AFULL_LVL);

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b = g;
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Reset release filters: assert asynchronously, release on each clock.
    logic [1:0] wrst_q, wrst_d;
    logic [1:0] rrst_q, rrst_d;
    logic       wrst, rrst;

    always_comb begin
        wrst_d = {wrst_q[0], 1'b0};
        rrst_d = {rrst_q[0], 1'b0};
    end

    always_ff @(posedge wrclk or posedge arst) begin
        if (arst) begin
            wrst_q <= 2'b11;
        end else begin
            wrst_q <= wrst_d;
        end
    end

    always_ff @(posedge rdclk or posedge arst) begin
        if (arst) begin
            rrst_q <= 2'b11;
        end else begin
            rrst_q <= rrst_d;
        end
    end

    assign wrst = wrst_q[1];
    assign rrst = rrst_q[1];

    logic [WIDTH-1:0] mem_q [DEPTH];

    // ---------------- write domain ----------------
    ptr_t wbin_q, wbin_d;
    ptr_t wgray_q, wgray_d;
    ptr_t wr_used_q, wr_used_d;
    ptr_t rs_bin;
    logic wrfull_q, wrfull_d;
    logic afull_q, afull_d;
    logic wr_en;

    (* preserve, async_reg = "true" *)
    ptr_t [SYNC_STAGES-1:0] rs_q;
    ptr_t [SYNC_STAGES-1:0] rs_d;

    (* preserve *)
    ptr_t [WR_DELAY-1:0] wdly_q;
    ptr_t [WR_DELAY-1:0] wdly_d;

    ptr_t relgray_q;

    always_comb begin
        wr_en     = wr.valid & ~wrfull_q;
        wbin_d    = wbin_q + ptr_t'(wr_en);
        wgray_d   = bin2gray(wbin_d);
        rs_bin    = gray2bin(rs_q[SYNC_STAGES-1]);
        wrfull_d  = wgray_d == (rs_q[SYNC_STAGES-1] ^ TOP2);
        wr_used_d = wbin_d - rs_bin;
        afull_d   = wr_used_d >= AFULL_P;
        rs_d      = rs_q;
        rs_d[0]   = relgray_q;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            rs_d[i] = rs_q[i-1];
        end
        wdly_d    = wdly_q;
        wdly_d[0] = wgray_q;
        for (int i = 1; i < WR_DELAY; i++) begin
            wdly_d[i] = wdly_q[i-1];
        end
    end

    // Full resets high so ready stays low until the filter releases.
    always_ff @(posedge wrclk or posedge wrst) begin
        if (wrst) begin
            wbin_q    <= '0;
            wgray_q   <= '0;
            wrfull_q  <= 1'b1;
            wr_used_q <= '0;
            afull_q   <= 1'b0;
            rs_q      <= '0;
            wdly_q    <= '0;
        end else begin
            wbin_q    <= wbin_d;
            wgray_q   <= wgray_d;
            wrfull_q  <= wrfull_d;
            wr_used_q <= wr_used_d;
            afull_q   <= afull_d;
            rs_q      <= rs_d;
            wdly_q    <= wdly_d;
        end
    end

    always_ff @(posedge wrclk) begin
        if (wr_en) begin
            mem_q[wbin_q[ADDR_W-1:0]] <= wr.data;
        end
    end

    assign wr.ready      = ~wrfull_q;
    assign o_wr_used     = wr_used_q;
    assign o_almost_full = afull_q;

    // ---------------- read domain ----------------
    ptr_t rbin_q, rbin_d;
    ptr_t relgray_d;
    ptr_t rd_used_q, rd_used_d;
    ptr_t ws_bin, rel_bin, skid_n;
    logic rdempty_q, rdempty_d;
    logic ram_pop;
    logic [WIDTH-1:0] ram_head;

    (* preserve, async_reg = "true" *)
    ptr_t [SYNC_STAGES-1:0] ws_q;
    ptr_t [SYNC_STAGES-1:0] ws_d;

    // Slots held in the skid stage are not yet released to the writer.
    always_comb begin
        ram_head  = mem_q[rbin_q[ADDR_W-1:0]];
        ws_bin    = gray2bin(ws_q[SYNC_STAGES-1]);
        rbin_d    = rbin_q + ptr_t'(ram_pop);
        rdempty_d = bin2gray(rbin_d) == ws_q[SYNC_STAGES-1];
        rel_bin   = rbin_d - skid_n;
        relgray_d = bin2gray(rel_bin);
        rd_used_d = ws_bin - rel_bin;
        ws_d      = ws_q;
        ws_d[0]   = wdly_q[WR_DELAY-1];
        for (int i = 1; i < SYNC_STAGES; i++) begin
            ws_d[i] = ws_q[i-1];
        end
    end

    always_ff @(posedge rdclk or posedge rrst) begin
        if (rrst) begin
            rbin_q    <= '0;
            relgray_q <= '0;
            rdempty_q <= 1'b1;
            rd_used_q <= '0;
            ws_q      <= '0;
        end else begin
            rbin_q    <= rbin_d;
            relgray_q <= relgray_d;
            rdempty_q <= rdempty_d;
            rd_used_q <= rd_used_d;
            ws_q      <= ws_d;
        end
    end

    assign o_rd_used = rd_used_q;

`ifdef CT_CLOCK_CROSS_REGOUT_EN
    logic [1:0]       sk_cnt_q, sk_cnt_d;
    logic [WIDTH-1:0] sk0_q, sk0_d;
    logic [WIDTH-1:0] sk1_q, sk1_d;
    logic             out_pop;

    always_comb begin
        out_pop  = rd.ready & (sk_cnt_q != 2'd0);
        ram_pop  = ~rdempty_q & ((sk_cnt_q != 2'd2) | out_pop);
        sk0_d    = sk0_q;
        sk1_d    = sk1_q;
        sk_cnt_d = sk_cnt_q;
        if (out_pop) begin
            sk0_d    = sk1_q;
            sk_cnt_d = sk_cnt_d - 2'd1;
        end
        if (ram_pop) begin
            if (sk_cnt_d == 2'd0) begin
                sk0_d = ram_head;
            end else begin
                sk1_d = ram_head;
            end
            sk_cnt_d = sk_cnt_d + 2'd1;
        end
        skid_n = ptr_t'(sk_cnt_d);
    end

    always_ff @(posedge rdclk or posedge rrst) begin
        if (rrst) begin
            sk_cnt_q <= 2'd0;
            sk0_q    <= '0;
            sk1_q    <= '0;
        end else begin
            sk_cnt_q <= sk_cnt_d;
            sk0_q    <= sk0_d;
            sk1_q    <= sk1_d;
        end
    end

    assign rd.valid = sk_cnt_q != 2'd0;
    assign rd.data  = sk0_q;
`else
    always_comb begin
        ram_pop = rd.ready & ~rdempty_q;
        skid_n  = '0;
    end

    assign rd.valid = ~rdempty_q;
    assign rd.data  = ram_head;
`endif

endmodule
